// File: rtl/bufferram_port_arbiter_if.sv
// Avalon-MM style burst master bundle for one requester of the buffer RAM arbiter.
// The master modport is the requester side, the slave modport is the arbiter side.
interface bufferram_port_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16,
    parameter int BE_W   = 2,
    parameter int BC_W   = 5
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [BC_W-1:0]   burstcount;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output read, write, address, burstcount, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  read, write, address, burstcount, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/bufferram_port_arbiter.sv
// Round-robin burst arbiter sharing one port of the 96000x16 output buffer RAM
// between two Avalon-MM style masters, with sticky out-of-range error flag.
module bufferram_port_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16,
    parameter int BE_W   = 2,
    parameter int DEPTH  = 96000,
    parameter int BC_W   = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    bufferram_port_arbiter_if.slave m0,
    bufferram_port_arbiter_if.slave m1,
    output logic                    ram_chipselect_o,
    output logic                    ram_write_o,
    output logic [ADDR_W-1:0]       ram_address_o,
    output logic [BE_W-1:0]         ram_byteenable_o,
    output logic [DATA_W-1:0]       ram_writedata_o,
    output logic                    ram_clken_o,
    input  logic [DATA_W-1:0]       ram_readdata_i,
    input  logic                    err_clear_i,
    output logic                    err_oob_o,
    output logic                    busy_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    localparam logic [BC_W-1:0] ONE     = BC_W'(1);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic              rr_q, rr_d;
    logic              owner_q, owner_d;
    logic [BC_W-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [BC_W-1:0]   len_q, len_d;
    logic              vld_p1;
    logic              own_p1;
    logic              oob_p1;

    logic              req0, req1, grant1;
    logic              own_write;
    logic [DATA_W-1:0] own_wd;
    logic [BE_W-1:0]   own_be;
    logic [BC_W-1:0]   bc_sel;
    logic [ADDR_W:0]   addr_ext;
    logic              oob, beat, last, own_open;

    assign req0   = m0.read | m0.write;
    assign req1   = m1.read | m1.write;
    assign grant1 = req1 & (~req0 | rr_q);
    assign bc_sel = grant1 ? m1.burstcount : m0.burstcount;

    assign own_write = owner_q ? m1.write      : m0.write;
    assign own_wd    = owner_q ? m1.writedata  : m0.writedata;
    assign own_be    = owner_q ? m1.byteenable : m0.byteenable;

    // One bit wider than the RAM address so base+i past the top of the space cannot wrap back in range.
    assign addr_ext = {1'b0, base_q} + {{(ADDR_W+1-BC_W){1'b0}}, cnt_q};
    assign oob      = addr_ext >= DEPTH_X;
    assign beat     = (state_q == S_RD) | ((state_q == S_WR) & own_write);
    assign last     = cnt_q == (len_q - ONE);
    assign own_open = (state_q == S_WR) | ((state_q == S_RD) & (cnt_q == '0));

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        len_d   = len_q;
        err_d   = err_q;
        if (beat && oob) begin
            err_d = 1'b1;
        end else if (err_clear_i) begin
            err_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d = grant1;
                    base_d  = grant1 ? m1.address : m0.address;
                    len_d   = (bc_sel == '0) ? ONE : bc_sel;
                    cnt_d   = '0;
                    state_d = (grant1 ? m1.write : m0.write) ? S_WR : S_RD;
                end
            end
            S_RD, S_WR: begin
                if (beat) begin
                    cnt_d = cnt_q + ONE;
                    if (last) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                        rr_d    = ~owner_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            vld_p1  <= state_q == S_RD;
        end
    end

    // Stage p1: RAM q for the beat issued last cycle lines up with its owner and range flag.
    always_ff @(posedge clk) begin
        base_q <= base_d;
        len_q  <= len_d;
        own_p1 <= owner_q;
        oob_p1 <= oob;
    end

    assign ram_chipselect_o = beat & ~oob;
    assign ram_write_o      = (state_q == S_WR) & own_write & ~oob;
    assign ram_address_o    = addr_ext[ADDR_W-1:0];
    assign ram_byteenable_o = own_be;
    assign ram_writedata_o  = own_wd;
    assign ram_clken_o      = 1'b1;

    assign m0.waitrequest   = ~(own_open & ~owner_q);
    assign m1.waitrequest   = ~(own_open & owner_q);
    assign m0.readdatavalid = vld_p1 & ~own_p1;
    assign m1.readdatavalid = vld_p1 & own_p1;
    assign m0.readdata      = (vld_p1 & ~own_p1 & ~oob_p1) ? ram_readdata_i : '0;
    assign m1.readdata      = (vld_p1 & own_p1 & ~oob_p1) ? ram_readdata_i : '0;

    assign busy_o    = state_q != S_IDLE;
    assign err_oob_o = err_q;
endmodule

// File: tb/tb_bufferram_port_arbiter.sv
// Bench for bufferram_port_arbiter: table of burst records, hand sequences for
// arbitration / error clear / reset abort, and random bursts against a shadow memory.
module tb_bufferram_port_arbiter;
    localparam int DEPTH = 96000;

    typedef struct {
        int m; int base; int bc; int dbase; int be_beat; int be_v;
        int stall_after; int stall_cyc; int exp_w; int exp_err;
    } vec_t;
    typedef struct { int m; logic [15:0] d; int c; } rbeat_t;
    typedef struct { int m; int c; } gnt_t;

    logic clk, reset, err_clear;
    logic [1:0] m_read, m_write, m_wait, m_rvld, prev_wait;
    logic [16:0] m_addr [2];
    logic [4:0]  m_bc [2];
    logic [15:0] m_wd [2];
    logic [1:0]  m_be [2];
    logic [15:0] m_rdata [2];
    logic ram_cs, ram_we, ram_clken, err_oob, busy;
    logic [16:0] ram_addr, raddr_q;
    logic [1:0]  ram_be;
    logic [15:0] ram_wd, ram_rd;

    logic [15:0] mem [0:DEPTH-1];
    logic [15:0] ref_mem [0:DEPTH-1];
    logic [15:0] last_rd [0:31];
    int wcnt, cyc, checks, errors;
    rbeat_t rq[$];
    gnt_t gq[$];
    vec_t tbl[7];

    bufferram_port_arbiter_if m0_if ();
    bufferram_port_arbiter_if m1_if ();

    assign m0_if.read = m_read[0];         assign m1_if.read = m_read[1];
    assign m0_if.write = m_write[0];       assign m1_if.write = m_write[1];
    assign m0_if.address = m_addr[0];      assign m1_if.address = m_addr[1];
    assign m0_if.burstcount = m_bc[0];     assign m1_if.burstcount = m_bc[1];
    assign m0_if.writedata = m_wd[0];      assign m1_if.writedata = m_wd[1];
    assign m0_if.byteenable = m_be[0];     assign m1_if.byteenable = m_be[1];
    assign m_wait = {m1_if.waitrequest, m0_if.waitrequest};
    assign m_rvld = {m1_if.readdatavalid, m0_if.readdatavalid};
    assign m_rdata[0] = m0_if.readdata;    assign m_rdata[1] = m1_if.readdata;

    bufferram_port_arbiter dut (
        .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if),
        .ram_chipselect_o(ram_cs), .ram_write_o(ram_we), .ram_address_o(ram_addr),
        .ram_byteenable_o(ram_be), .ram_writedata_o(ram_wd), .ram_clken_o(ram_clken),
        .ram_readdata_i(ram_rd), .err_clear_i(err_clear), .err_oob_o(err_oob), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
        return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
    endfunction

    // RAM port model: registered address, unregistered q.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_cs && ram_we) begin
            wcnt <= wcnt + 1;
            if (ram_addr < 17'(DEPTH)) mem[ram_addr] <= merge(mem[ram_addr], ram_wd, ram_be);
        end
        raddr_q <= ram_addr;
    end
    assign ram_rd = (raddr_q < 17'(DEPTH)) ? mem[raddr_q] : 16'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_rvld[i]) rq.push_back('{i, m_rdata[i], cyc});
            else chk("rdata_zero_when_invalid", 32'(m_rdata[i]), 0);
            if (!m_wait[i]) chk("waitreq_low_only_busy", 32'(busy), 1);
            if (prev_wait[i] && !m_wait[i]) gq.push_back('{i, cyc});
        end
        prev_wait <= m_wait;
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); err_clear = 1'b0;
        chk("err_after_clear", 32'(err_oob), 0);
    endtask

    task automatic rd_cmd(input int m, input int base, input int bc, output int acc);
        int guard;
        guard = 0; acc = -1;
        m_addr[m] = 17'(base); m_bc[m] = 5'(bc); m_read[m] = 1'b1;
        while (acc < 0 && guard < 200) begin
            @(negedge clk); guard++;
            if (!m_wait[m]) begin
                @(posedge clk); #1;
                acc = cyc;
            end
        end
        m_read[m] = 1'b0;
        if (acc < 0) chk("rd_accept_timeout", 0, 1);
    endtask

    task automatic rd_burst(input int m, input int base, input int bc);
        int n, acc, guard, a;
        n = (bc == 0) ? 1 : bc;
        @(posedge clk); #1;
        rq.delete();
        rd_cmd(m, base, bc, acc);
        guard = 0;
        while (rq.size() < n && guard < 80) begin @(negedge clk); #1; guard++; end
        @(negedge clk); #1;
        chk("rd_beats", rq.size(), n);
        foreach (rq[k]) begin
            a = base + k;
            chk("rd_owner", rq[k].m, m);
            chk("rd_data", 32'(rq[k].d), (a < DEPTH) ? 32'(ref_mem[a]) : 0);
            chk("rd_cycle", rq[k].c, acc + k);
            if (k < 32) last_rd[k] = rq[k].d;
        end
    endtask

    task automatic wr_burst(input vec_t v);
        int n, i, guard, a;
        n = (v.bc == 0) ? 1 : v.bc; i = 0; guard = 0;
        m_addr[v.m] = 17'(v.base); m_bc[v.m] = 5'(v.bc);
        m_wd[v.m] = 16'(v.dbase);
        m_be[v.m] = (v.be_beat == 0) ? 2'(v.be_v) : 2'b11;
        m_write[v.m] = 1'b1;
        while (i < n && guard < 400) begin
            @(negedge clk); guard++;
            if (!m_wait[v.m]) begin
                @(posedge clk); #1;
                a = v.base + i;
                if (a < DEPTH) ref_mem[a] = merge(ref_mem[a], m_wd[v.m], m_be[v.m]);
                i++;
                if (i < n) begin
                    if (i == v.stall_after) begin
                        m_write[v.m] = 1'b0;
                        repeat (v.stall_cyc) begin
                            @(negedge clk);
                            chk("stall_no_ram_access", 32'(ram_cs), 0);
                            @(posedge clk); #1;
                        end
                    end
                    m_wd[v.m] = 16'(v.dbase + i);
                    m_be[v.m] = (i == v.be_beat) ? 2'(v.be_v) : 2'b11;
                    m_write[v.m] = 1'b1;
                end
            end
        end
        m_write[v.m] = 1'b0;
        if (i < n) chk("wr_beats_timeout", i, n);
    endtask

    task automatic run_row(input vec_t v);
        int w0;
        pulse_clear();
        w0 = wcnt;
        wr_burst(v);
        chk("busy_drops_after_write", 32'(busy), 0);
        chk("ram_write_count", wcnt - w0, v.exp_w);
        chk("err_oob_after_write", 32'(err_oob), v.exp_err);
        @(negedge clk);
        rd_burst(1 - v.m, v.base, v.bc);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, n;
        vec_t v;
        checks = 0; errors = 0; wcnt = 0; cyc = 0;
        for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        reset = 1'b1; err_clear = 1'b0; m_read = '0; m_write = '0; prev_wait = 2'b11;
        for (int i = 0; i < 2; i++) begin m_addr[i] = '0; m_bc[i] = '0; m_wd[i] = '0; m_be[i] = '0; end

        //       m  base      bc  dbase   be_beat be_v st_after st_cyc exp_w exp_err
        tbl[0] = '{0, 'h10,    4, 'hA001, -1, 3, 0, 0, 4, 0};
        tbl[1] = '{0, 95998,   4, 'h5000, -1, 3, 0, 0, 2, 1};
        tbl[2] = '{0, 'h20,    3, 'h1111, -1, 3, 0, 0, 3, 0};
        tbl[3] = '{1, 'h20,    3, 'hBB00,  1, 1, 1, 2, 3, 0};
        tbl[4] = '{1, 'h400,   0, 'h7777, -1, 3, 0, 0, 1, 0};
        tbl[5] = '{1, 96000,   1, 'h3333, -1, 3, 0, 0, 0, 1};
        tbl[6] = '{0, 'h1FFF0, 31, 'h4000, -1, 3, 5, 1, 0, 1};

        repeat (2) @(negedge clk);
        chk("rst_m0_waitrequest", 32'(m_wait[0]), 1);
        chk("rst_m1_waitrequest", 32'(m_wait[1]), 1);
        chk("rst_readdatavalid", 32'(m_rvld), 0);
        chk("rst_ram_chipselect", 32'(ram_cs), 0);
        chk("rst_ram_write", 32'(ram_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err_oob", 32'(err_oob), 0);
        chk("ram_clken_tied", 32'(ram_clken), 1);
        @(posedge clk); #1 reset = 1'b0;

        for (int k = 0; k < 7; k++) begin
            run_row(tbl[k]);
            if (k == 3) chk("byteenable_low_only", 32'(last_rd[1]), 32'h1101);
            if (k == 1) chk("oob_read_third_beat", 32'(last_rd[2]), 0);
        end

        // Simultaneous requests after reset: m0, m1, then m0 again, one IDLE cycle apart.
        do_reset();
        gq.delete();
        fork
            begin rd_cmd(0, 'h10, 2, a0); rd_cmd(0, 'h12, 2, a2); end
            begin rd_cmd(1, 'h20, 2, a1); end
        join
        repeat (4) @(negedge clk);
        chk("arb_grant_count", gq.size(), 3);
        if (gq.size() == 3) begin
            chk("arb_first_m0", gq[0].m, 0);
            chk("arb_second_m1", gq[1].m, 1);
            chk("arb_third_m0", gq[2].m, 0);
            chk("arb_gap_1", gq[1].c - gq[0].c, 3);
            chk("arb_gap_2", gq[2].c - gq[1].c, 3);
        end

        // A new out-of-range beat beats a simultaneous err_clear.
        pulse_clear();
        err_clear = 1'b1;
        wr_burst('{0, 96000, 1, 'h1234, -1, 3, 0, 0, 0, 1});
        chk("err_wins_over_clear", 32'(err_oob), 1);
        @(posedge clk); #1;
        chk("err_clear_next_cycle", 32'(err_oob), 0);
        err_clear = 1'b0;

        // Reset during beat 2 of an 8-beat read; rr pointer was left on m1 beforehand.
        rd_cmd(0, 'h10, 2, a0);
        repeat (3) @(negedge clk);
        rd_cmd(0, 'h10, 8, a0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_chipselect", 32'(ram_cs), 0);
        chk("midrst_waitrequest", 32'(m_wait), 3);
        chk("midrst_valid", 32'(m_rvld), 0);
        chk("midrst_rdata", 32'(m_rdata[0]), 0);
        rq.delete();
        @(posedge clk); #1 reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_no_late_valid", rq.size(), 0);
        gq.delete();
        fork
            rd_cmd(0, 'h30, 1, a0);
            rd_cmd(1, 'h31, 1, a1);
        join
        repeat (2) @(negedge clk);
        chk("midrst_grants", gq.size(), 2);
        if (gq.size() > 0) chk("midrst_rr_is_m0", gq[0].m, 0);

        // Random bursts against the shadow memory.
        for (int r = 0; r < 30; r++) begin
            v.m = $urandom_range(0, 1);
            v.bc = $urandom_range(0, 12);
            v.base = ($urandom_range(0, 3) == 0) ? DEPTH - 10 + $urandom_range(0, 12)
                                                 : $urandom_range(0, DEPTH - 1);
            v.dbase = $urandom_range(0, 65535);
            v.be_beat = $urandom_range(0, 12) - 1;
            v.be_v = $urandom_range(0, 3);
            v.stall_after = $urandom_range(0, 4);
            v.stall_cyc = $urandom_range(1, 3);
            n = (v.bc == 0) ? 1 : v.bc;
            v.exp_w = 0;
            for (int i = 0; i < n; i++) if (v.base + i < DEPTH) v.exp_w++;
            v.exp_err = (v.exp_w < n) ? 1 : 0;
            run_row(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bufferram_port_arbiter.md
Name: bufferram_port_arbiter

Overview:
Two-requester round-robin burst arbiter that shares one port of the 96000x16 output buffer RAM between an Avalon-MM-style writer and an Avalon-MM-style reader (e.g. the compute engine storing results and the host/display reading them).
- Latches each burst command and generates sequential word addresses.
- Drives the RAM port signals and returns read data with per-beat valid.
- Flags out-of-range accesses with a sticky error.

Parameters:
ADDR_W, 17, word address width of RAM and masters
DATA_W, 16, data width
BE_W, 2, byteenable width (DATA_W/8)
DEPTH, 96000, number of valid RAM words
BC_W, 5, burstcount width (max burst 2^BC_W-1 beats)

Ports:
clk  in  1  single clock for block and RAM port
reset  in  1  asynchronous, active-high reset
mN_read  in  1  read command, N in {0,1} (one line per master, identical set)
mN_write  in  1  write command / write beat
mN_address  in  ADDR_W  burst start word address
mN_burstcount  in  BC_W  beats in burst; 0 treated as 1
mN_writedata  in  DATA_W  write beat data
mN_byteenable  in  BE_W  write beat byte lanes
mN_waitrequest  out  1  high = command/beat not accepted
mN_readdata  out  DATA_W  read beat data
mN_readdatavalid  out  1  read beat valid
ram_chipselect  out  1  RAM port select
ram_write  out  1  RAM write strobe
ram_address  out  ADDR_W  RAM word address
ram_byteenable  out  BE_W  RAM byte lanes
ram_writedata  out  DATA_W  RAM write data
ram_clken  out  1  tied 1
ram_readdata  in  DATA_W  RAM q (address registered in RAM, q unregistered: 1-cycle read latency)
err_clear  in  1  clears err_oob
err_oob  out  1  sticky: burst beat addressed word >= DEPTH
busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - state IDLE; rr pointer = m0; beat counter 0; err_oob 0.
  - mN_waitrequest 1; mN_readdatavalid 0; mN_readdata 0.
  - ram_chipselect 0; ram_write 0; busy 0.
- FSM states: IDLE, RD, WR.
- IDLE arbitration:
  - Requesters are masters with read|write high. If both request, the rr pointer holder wins.
  - Latch owner, base = address, len = max(burstcount,1), dir (write wins if a master asserts both).
  - Go to RD or WR. waitrequest stays high in IDLE; masters must hold command stable (Avalon rule).
- RD:
  - Cycle 0: owner waitrequest=0 (command accepted). Every RD cycle, beat i drives ram_chipselect=1, ram_address=base+i.
  - Exit to IDLE after len cycles; waitrequest high after cycle 0.
  - Beat i data appears on owner mN_readdata with mN_readdatavalid=1 at cycle i+1. This is a registered owner/valid pipeline; the last beat's valid occurs in IDLE.
  - Non-owner readdatavalid is always 0; readdata is 0 when not valid.
- WR:
  - Owner waitrequest=0 for the whole state. A beat is accepted when owner write=1: ram_write=ram_chipselect=1, ram_address=base+i, data/byteenable passed from owner, i++.
  - write=0 stalls (no RAM access).
  - Exit to IDLE in the cycle after the len-th accepted beat; waitrequest returns high that cycle.
- Address rules:
  - ram_address = base+i is computed ADDR_W+1 bits wide.
  - A beat with base+i >= DEPTH sets err_oob. RAM is not selected; writes are dropped; reads return 0 with valid still asserted. The burst still completes.
- rr pointer flips to the other master when a burst ends.
- Minimum 1 IDLE cycle between bursts; no starvation: a continuously requesting master waits at most one burst.
- err_clear and a same-cycle new error: error wins (err_oob stays 1).
- Reset mid-burst:
  - Immediate return to reset values; remaining beats abandoned.
  - Already-written words persist.
  - In-flight readdatavalid is suppressed.

Test Plan:
1. m0 write base 0x00010, burstcount 4, data 0xA001..0xA004, byteenable 2'b11 -> ram_write on 4 cycles at 0x10..0x13; m0_waitrequest low only in WR; busy drops next cycle.
2. m1 read base 0x00010, burstcount 4 after test 1 -> m1_readdatavalid on 4 consecutive cycles starting 1 cycle after acceptance, data 0xA001..0xA004; m0_readdatavalid stays 0.
3. m0 and m1 both request in the same cycle after reset, each burst 2, m0 reissuing immediately -> order m0, m1, m0. Each grant is separated by exactly one IDLE cycle.
4. m0 write base 95998 burstcount 4 -> writes at 95998, 95999 only; err_oob=1 from the third beat. m1 read of the same range returns two values then 0x0000, 0x0000; err_clear pulse -> err_oob 0.
5. Write burst 3 with m0_write low for 2 cycles between beats 1 and 2 -> no RAM access while stalled; 3 writes total; byteenable 2'b01 beat changes only the low byte.
6. Assert reset during beat 2 of an 8-beat read -> all outputs at reset values the same cycle. No further readdatavalid; the next request is granted normally with rr = m0.
